// File: rtl/alu_pkg.sv
// Shared constants, instruction field layout and FSM state type for the ALU issue controller.
package alu_pkg;

  localparam int DATA_W   = 8;
  localparam int OP_W     = 4;
  localparam int NUM_REGS = 4;

  // Op codes
  localparam logic [OP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [OP_W-1:0] ALU_SUB = 4'd1;
  localparam logic [OP_W-1:0] ALU_AND = 4'd2;
  localparam logic [OP_W-1:0] ALU_OR  = 4'd3;
  localparam logic [OP_W-1:0] ALU_SLT = 4'd4;
  localparam logic [OP_W-1:0] ALU_XOR = 4'd5;
  localparam logic [OP_W-1:0] OP_LDI  = 4'd8;

  // Instruction field bit positions
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 10;
  localparam int RS1_HI = 9;
  localparam int RS1_LO = 8;
  localparam int RS2_HI = 7;
  localparam int RS2_LO = 6;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_WB
  } state_t;

  // ALU ops occupy the contiguous range ADD..XOR
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return op <= ALU_XOR;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Small register file: async reset to zero, two combinational read ports,
// a combinational debug read port and one synchronous write port.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int NREGS = NUM_REGS,
  parameter int DW    = DATA_W,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata2,
  input  logic [AW-1:0] dbg_sel,
  output logic [DW-1:0] dbg_data
);

  logic [NREGS-1:0][DW-1:0] regs;

  // Storage: cleared on reset, single write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     regs        <= '0;
    else if (we) regs[waddr] <= wdata;
  end

  assign rdata1   = regs[raddr1];
  assign rdata2   = regs[raddr2];
  assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts one instruction at a time, reads operands,
// drives the external combinational ALU and writes its result back.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W   = alu_pkg::DATA_W,
  parameter int OP_W     = alu_pkg::OP_W,
  parameter int NUM_REGS = alu_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  output logic              done,
  output logic              illegal,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int AW = $clog2(NUM_REGS);

  state_t            state, state_nxt;
  logic [15:0]       ir;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] rdata1, rdata2;
  logic              illegal_q;

  logic [OP_W-1:0] ir_op;
  logic            op_alu, op_ldi;

  assign ir_op  = ir[OP_HI:OP_LO];
  assign op_alu = is_alu_op(ir_op);
  assign op_ldi = (ir_op == OP_LDI);

  assign instr_ready = (state == ST_IDLE);
  assign done        = (state == ST_WB);
  assign illegal     = illegal_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: ALU ops take the EXEC detour, LDI skips it, illegal ops bail out
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (instr_valid) state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (op_alu)      state_nxt = ST_EXEC;
        else if (op_ldi) state_nxt = ST_WB;
        else             state_nxt = ST_IDLE;
      end
      ST_EXEC:   state_nxt = ST_WB;
      ST_WB:     state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: instruction latch, ALU operand registers, result register, illegal flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir        <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      result    <= '0;
      illegal_q <= 1'b0;
    end else begin
      // Pulse for exactly the IDLE cycle following a rejected decode
      illegal_q <= (state == ST_DECODE) && !op_alu && !op_ldi;
      case (state)
        ST_IDLE:   if (instr_valid) ir <= instr;
        ST_DECODE: begin
          if (op_alu) begin
            alu_a  <= rdata1;
            alu_b  <= rdata2;
            alu_op <= ir_op;
          end else if (op_ldi) begin
            result <= ir[IMM_HI:IMM_LO];
          end
        end
        ST_EXEC:   result <= alu_out;
        default:   ;
      endcase
    end
  end

  alu_regfile #(
    .NREGS (NUM_REGS),
    .DW    (DATA_W),
    .AW    (AW)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .we       (state == ST_WB),
    .waddr    (ir[RD_HI:RD_LO]),
    .wdata    (result),
    .raddr1   (ir[RS1_HI:RS1_LO]),
    .rdata1   (rdata1),
    .raddr2   (ir[RS2_HI:RS2_LO]),
    .rdata2   (rdata2),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

endmodule
